// File: rtl/sequence_pkg.sv
// Shared detection-code constants and event-entry sizing used by the scanner
// and the event log.
package sequence_pkg;

    localparam logic [1:0] Z_NONE = 2'b00;
    localparam logic [1:0] Z_RSVD = 2'b01;
    localparam logic [1:0] Z_A    = 2'b10;
    localparam logic [1:0] Z_B    = 2'b11;

    localparam int CODE_W = 2;

    // An event entry is {code, stamp}.
    function automatic int evt_w(input int ts_w);
        return CODE_W + ts_w;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// First-word-fall-through FIFO with simultaneous push/pop, synchronous clear
// and an occupancy level output.
module event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_L);
    assign level = count;
    assign rdata = mem[rptr];

    // A pop frees the head slot this cycle, so a full FIFO may still accept.
    assign do_pop  = pop && !empty && !clr;
    assign do_push = push && (!full || do_pop) && !clr;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sequence_event_log.sv
// Logs pattern-A/B detections as time-stamped events in a FIFO, with
// saturating hit counters and sticky overflow / reserved-code flags.
module sequence_event_log
    import sequence_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8,
    parameter int TS_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               Z,
    input  logic                     clr,
    input  logic                     evt_ready,
    output logic                     evt_valid,
    output logic [1:0]               evt_code,
    output logic [TS_W-1:0]          evt_stamp,
    output logic [CNT_W-1:0]         cnt_a,
    output logic [CNT_W-1:0]         cnt_b,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    output logic                     err
);

    localparam int EW = evt_w(TS_W);

    logic [TS_W-1:0] ts;
    logic            is_evt;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_pop;
    logic [EW-1:0]   head;

    assign is_evt = (Z == Z_A) || (Z == Z_B);

    // Handshake: an event is consumed in any cycle where evt_valid and
    // evt_ready are both high; evt_ready alone while empty does nothing.
    assign fifo_pop  = evt_valid && evt_ready;
    assign evt_valid = !fifo_empty;
    assign evt_code  = head[EW-1 -: CODE_W];
    assign evt_stamp = head[TS_W-1:0];

    event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (is_evt),
        .pop   (fifo_pop),
        .wdata ({Z, ts}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts    <= '0;
            cnt_a <= '0;
            cnt_b <= '0;
            ovf   <= 1'b0;
            err   <= 1'b0;
        end else if (clr) begin
            ts    <= '0;
            cnt_a <= '0;
            cnt_b <= '0;
            ovf   <= 1'b0;
            err   <= 1'b0;
        end else begin
            ts <= ts + 1'b1;
            if ((Z == Z_A) && (cnt_a != '1)) begin
                cnt_a <= cnt_a + 1'b1;
            end
            if ((Z == Z_B) && (cnt_b != '1)) begin
                cnt_b <= cnt_b + 1'b1;
            end
            // Dropped only when full and the head is not leaving this cycle.
            if (is_evt && fifo_full && !fifo_pop) begin
                ovf <= 1'b1;
            end
            if (Z == Z_RSVD) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sequence_event_log.sv
// Self-checking bench for sequence_event_log: directed table, hand sequences
// for reset/saturation corners and randomized traffic against a queue model.
module tb_sequence_event_log;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int TS_W  = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic [1:0]             Z = 2'b00;
    logic                   clr = 1'b0;
    logic                   evt_ready = 1'b0;
    logic                   evt_valid;
    logic [1:0]             evt_code;
    logic [TS_W-1:0]        evt_stamp;
    logic [CNT_W-1:0]       cnt_a;
    logic [CNT_W-1:0]       cnt_b;
    logic [$clog2(DEPTH):0] level;
    logic                   ovf;
    logic                   err;

    sequence_event_log #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W),
        .TS_W  (TS_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .Z         (Z),
        .clr       (clr),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_stamp (evt_stamp),
        .cnt_a     (cnt_a),
        .cnt_b     (cnt_b),
        .level     (level),
        .ovf       (ovf),
        .err       (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: queue of {code, stamp} plus plain integer state.
    logic [TS_W+1:0] exp_q[$];
    int m_a, m_b, m_ts;
    bit m_ovf, m_err;

    typedef struct {
        logic [1:0] z;
        bit         rdy;
        bit         c;
        int         lvl;
        bit         v;
        int         a;
        int         b;
        bit         o;
        bit         e;
        logic [1:0] code;
    } vec_t;

    vec_t tbl[21];

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_a = 0; m_b = 0; m_ts = 0;
        m_ovf = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_step(input logic [1:0] z, input bit rdy, input bit c);
        bit pop;
        pop = (exp_q.size() > 0) && rdy;
        if (c) begin
            model_reset();
        end else begin
            if (z == 2'b01) m_err = 1'b1;
            if (z == 2'b10 && m_a < CMAX) m_a++;
            if (z == 2'b11 && m_b < CMAX) m_b++;
            if (pop) void'(exp_q.pop_front());
            if (z[1]) begin
                if (exp_q.size() < DEPTH) exp_q.push_back({z, m_ts[TS_W-1:0]});
                else m_ovf = 1'b1;
            end
            m_ts = (m_ts + 1) % (1 << TS_W);
        end
    endtask

    task automatic check_model();
        logic [TS_W+1:0] h;
        check("valid", int'(evt_valid), int'(exp_q.size() > 0));
        check("level", int'(level), exp_q.size());
        check("cnt_a", int'(cnt_a), m_a);
        check("cnt_b", int'(cnt_b), m_b);
        check("ovf", int'(ovf), int'(m_ovf));
        check("err", int'(err), int'(m_err));
        if (exp_q.size() > 0) begin
            h = exp_q[0];
            check("head_code", int'(evt_code), int'(h[TS_W+1:TS_W]));
            check("head_stamp", int'(evt_stamp), int'(h[TS_W-1:0]));
        end
    endtask

    // Drive one cycle from just after a falling edge, then check after the next.
    task automatic cycle(input logic [1:0] z, input bit rdy, input bit c);
        Z = z;
        evt_ready = rdy;
        clr = c;
        model_step(z, rdy, c);
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    initial begin
        tbl[0]  = '{2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00};
        tbl[1]  = '{2'b10, 0, 0, 1, 1, 1, 0, 0, 0, 2'b10};
        tbl[2]  = '{2'b11, 0, 0, 2, 1, 1, 1, 0, 0, 2'b10};
        tbl[3]  = '{2'b10, 0, 0, 3, 1, 2, 1, 0, 0, 2'b10};
        tbl[4]  = '{2'b11, 0, 0, 4, 1, 2, 2, 0, 0, 2'b10};
        tbl[5]  = '{2'b10, 0, 0, 4, 1, 3, 2, 1, 0, 2'b10};
        tbl[6]  = '{2'b00, 1, 0, 3, 1, 3, 2, 1, 0, 2'b11};
        tbl[7]  = '{2'b00, 1, 0, 2, 1, 3, 2, 1, 0, 2'b10};
        tbl[8]  = '{2'b00, 1, 0, 1, 1, 3, 2, 1, 0, 2'b11};
        tbl[9]  = '{2'b00, 1, 0, 0, 0, 3, 2, 1, 0, 2'b00};
        tbl[10] = '{2'b01, 0, 0, 0, 0, 3, 2, 1, 1, 2'b00};
        tbl[11] = '{2'b10, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00};
        tbl[12] = '{2'b10, 0, 0, 1, 1, 1, 0, 0, 0, 2'b10};
        tbl[13] = '{2'b10, 0, 0, 2, 1, 2, 0, 0, 0, 2'b10};
        tbl[14] = '{2'b10, 0, 0, 3, 1, 3, 0, 0, 0, 2'b10};
        tbl[15] = '{2'b10, 0, 0, 4, 1, 4, 0, 0, 0, 2'b10};
        tbl[16] = '{2'b11, 1, 0, 4, 1, 4, 1, 0, 0, 2'b10};
        tbl[17] = '{2'b00, 1, 0, 3, 1, 4, 1, 0, 0, 2'b10};
        tbl[18] = '{2'b00, 1, 0, 2, 1, 4, 1, 0, 0, 2'b10};
        tbl[19] = '{2'b00, 1, 0, 1, 1, 4, 1, 0, 0, 2'b11};
        tbl[20] = '{2'b00, 1, 0, 0, 0, 4, 1, 0, 0, 2'b00};

        // Reset state.
        model_reset();
        repeat (2) @(negedge clk);
        check_model();
        rst = 1'b1;

        // First event after reset: Z=A in cycle 5 carries stamp 5.
        for (int i = 0; i < 5; i++) cycle(2'b00, 1'b0, 1'b0);
        cycle(2'b10, 1'b0, 1'b0);
        check("first_valid", int'(evt_valid), 1);
        check("first_code", int'(evt_code), 2);
        check("first_stamp", int'(evt_stamp), 5);
        check("first_cnt_a", int'(cnt_a), 1);
        check("first_level", int'(level), 1);

        // Directed table: overflow, drain order, reserved code, clr priority,
        // push+pop while full.
        for (int i = 0; i < 21; i++) begin
            cycle(tbl[i].z, tbl[i].rdy, tbl[i].c);
            check($sformatf("tbl%0d_level", i), int'(level), tbl[i].lvl);
            check($sformatf("tbl%0d_valid", i), int'(evt_valid), int'(tbl[i].v));
            check($sformatf("tbl%0d_cnt_a", i), int'(cnt_a), tbl[i].a);
            check($sformatf("tbl%0d_cnt_b", i), int'(cnt_b), tbl[i].b);
            check($sformatf("tbl%0d_ovf", i), int'(ovf), int'(tbl[i].o));
            check($sformatf("tbl%0d_err", i), int'(err), int'(tbl[i].e));
            if (tbl[i].v) check($sformatf("tbl%0d_code", i), int'(evt_code), int'(tbl[i].code));
        end

        // Counter saturation and stamp wrap under continuous B traffic.
        cycle(2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) cycle(2'b11, 1'b1, 1'b0);
        check("sat_cnt_b", int'(cnt_b), CMAX);
        check("sat_level", int'(level), 1);

        // Randomized traffic.
        cycle(2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 600; i++) begin
            cycle(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 39) == 0);
        end

        // Asynchronous reset mid-operation with three stored events.
        cycle(2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(2'b10, 1'b0, 1'b0);
        check("pre_rst_level", int'(level), 3);
        Z = 2'b00;
        #2;
        rst = 1'b0;
        #1;
        check("rst_valid", int'(evt_valid), 0);
        check("rst_level", int'(level), 0);
        check("rst_cnt_a", int'(cnt_a), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cycle(2'b10, 1'b0, 1'b0);
        check("post_rst_stamp", int'(evt_stamp), 0);
        check("post_rst_level", int'(level), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sequence_event_log.md
SEQUENCE_EVENT_LOG -- requirements
Module: sequence_event_log

Interface
REQ-001 Parameter DEPTH, default 4: event FIFO depth in entries; SHALL be a power of two, at least 2.
REQ-002 Parameter CNT_W, default 8: width of each per-pattern hit counter.
REQ-003 Parameter TS_W, default 8: width of the timestamp counter and of each stamp.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 Z  in  2  detection code from the sequence scanner, sampled every clk.
REQ-007 clr  in  1  synchronous clear of counters, FIFO, flags and timestamp.
REQ-008 evt_ready  in  1  consumer accepts the head event.
REQ-009 evt_valid  out  1  FIFO not empty; a head event is presented.
REQ-010 evt_code  out  2  code of the head event.
REQ-011 evt_stamp  out  TS_W  timestamp of the head event.
REQ-012 cnt_a  out  CNT_W  count of pattern-A hits (code 2'b10, sequence 0-1-3-2).
REQ-013 cnt_b  out  CNT_W  count of pattern-B hits (code 2'b11, sequence 0-2-3-1).
REQ-014 level  out  clog2(DEPTH)+1  number of entries held in the FIFO.
REQ-015 ovf  out  1  sticky flag: at least one event was dropped because the FIFO was full.
REQ-016 err  out  1  sticky flag: reserved code 2'b01 was seen on Z.

Function
REQ-017 Z SHALL be treated as a one-cycle Mealy pulse: every cycle with Z of 2'b10 or 2'b11 SHALL be one event; back-to-back cycles give back-to-back events.
REQ-018 Z of 2'b00 SHALL be ignored; Z of 2'b01 SHALL set err and SHALL NOT create an event or change any count.
REQ-019 Timestamp counter: free-running TS_W bits, +1 every cycle, wraps from all-ones to 0.
REQ-020 The timestamp value in cycle n SHALL be the stamp of an event sampled in cycle n.
REQ-021 Event in cycle n SHALL increment cnt_a or cnt_b at edge n+1; counters SHALL saturate at all-ones.
REQ-022 Event in cycle n SHALL push {code, stamp} at edge n+1; with the FIFO empty, evt_valid SHALL be 1 in cycle n+1.
REQ-023 The FIFO SHALL be first-word-fall-through: evt_code and evt_stamp SHALL always show the head entry; their value while evt_valid=0 is don't-care.
REQ-024 Pop SHALL occur when evt_valid and evt_ready are both 1; evt_ready while empty SHALL have no effect.
REQ-025 Push and pop in the same cycle SHALL both occur and leave level unchanged; this also applies when full.
REQ-026 Push while full without pop: event SHALL be dropped, ovf SHALL be set, counters SHALL still increment.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH.
REQ-028 clr=1 SHALL zero counters, FIFO (level=0), ovf, err and timestamp at the next edge.
REQ-029 An event and a pop coinciding with clr SHALL be discarded; clr wins.

Reset
REQ-030 rst low SHALL immediately clear: cnt_a=0, cnt_b=0, level=0, evt_valid=0, ovf=0, err=0, timestamp=0, pointers=0.
REQ-031 Deassertion of rst SHALL be synchronised externally; the block SHALL resume counting at the first edge after release.
REQ-032 Reset mid-operation SHALL discard all stored events; no partial entry SHALL survive.

Structure
REQ-033 A shared package sequence_pkg SHALL hold the code constants Z_NONE=2'b00, Z_RSVD=2'b01, Z_A=2'b10, Z_B=2'b11 and the event-entry width (2+TS_W); the scanner and this block SHALL both use it.
REQ-034 The FIFO SHALL be one sub-module, event_fifo (parameters DEPTH and width; push/pop/full/empty/level); counters, flags and timestamp SHALL stay in the top level.

Verification
REQ-035 After reset: Z=10 in cycle 5, evt_ready=0 -> cycle 6: evt_valid=1, evt_code=10, evt_stamp=5, cnt_a=1, level=1.
REQ-036 Z=10, 11, 10, 11, 10 on consecutive cycles, evt_ready=0, DEPTH=4 -> level=4, ovf=1, cnt_a=3, cnt_b=2; drained order is 10, 11, 10, 11.
REQ-037 FIFO full, evt_ready=1, Z=11 in the same cycle -> level stays 4, ovf stays 0, new tail is code 11.
REQ-038 300 cycles of Z=11 with evt_ready=1 -> cnt_b=255 (saturated); stamps wrap 255->0 in order.
REQ-039 Z=01 -> err=1, level and counts unchanged; clr together with Z=10 -> all counts and flags 0, level=0.
REQ-040 rst asserted low while level=3 -> evt_valid=0 and level=0 with no clock edge; after release, Z=10 -> stamp counts from 0.
